// File: rtl/rf_wb_if.sv
// rf_wb_if: issue, writeback, long-latency and register-file signals of the write-port scheduler
interface rf_wb_if #(parameter int DW = 32, parameter int AW = 5);
  logic issue_valid, issue_rs_rd, issue_rt_rd, issue_we, issue_long, stall;
  logic [AW-1:0] issue_rs, issue_rt, issue_dst;
  logic wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic lu_valid, lu_ready;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [2**AW-1:0] busy_vec;
  modport master (
    output issue_valid, issue_rs_rd, issue_rt_rd, issue_rs, issue_rt, issue_we, issue_dst, issue_long,
    output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    input stall, lu_ready, rf_we, rf_waddr, rf_wdata, busy_vec
  );
  modport slave (
    input issue_valid, issue_rs_rd, issue_rt_rd, issue_rs, issue_rt, issue_we, issue_dst, issue_long,
    input wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    output stall, lu_ready, rf_we, rf_waddr, rf_wdata, busy_vec
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: register-file write-port arbiter with long-latency skid buffer and busy-bit hazard scoreboard
module rf_wb_scheduler #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic   clk,
  input logic   rst,
  rf_wb_if.slave bus
);
  localparam int NR = 2**AW;
  logic [NR-1:0] busy_q, busy_d;
  logic buf_valid_q, buf_valid_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [DW-1:0] buf_data_q, buf_data_d;
  logic rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic wb_win, drain, accept, set_busy;
  // busy[0] is held at zero, so reads of r0 never hazard
  assign bus.stall = !rst && bus.issue_valid &&
                     ((bus.issue_rs_rd && busy_q[bus.issue_rs]) ||
                      (bus.issue_rt_rd && busy_q[bus.issue_rt]) ||
                      (bus.issue_we && busy_q[bus.issue_dst]));
  assign bus.lu_ready = !rst && !buf_valid_q;
  assign bus.rf_we = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy_vec = busy_q;
  always_comb begin
    wb_win = bus.wb_we && |bus.wb_addr;
    drain = !wb_win && buf_valid_q;
    accept = bus.lu_valid && bus.lu_ready;
    set_busy = bus.issue_valid && !bus.stall && bus.issue_long && bus.issue_we && |bus.issue_dst;
    busy_d = busy_q;
    if (drain) busy_d[buf_addr_q] = 1'b0;
    if (set_busy) busy_d[bus.issue_dst] = 1'b1;
    busy_d[0] = 1'b0;
    buf_valid_d = accept ? |bus.lu_addr : buf_valid_q && !drain;
    buf_addr_d = accept ? bus.lu_addr : buf_addr_q;
    buf_data_d = accept ? bus.lu_data : buf_data_q;
    rf_we_d = wb_win || drain;
    rf_waddr_d = wb_win ? bus.wb_addr : drain ? buf_addr_q : rf_waddr_q;
    rf_wdata_d = wb_win ? bus.wb_data : drain ? buf_data_q : rf_wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q <= busy_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed and random stimulus against a queue/bitset model of the write-port scheduler
module tb_rf_wb_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  rf_wb_if #(.DW(32), .AW(5)) bus();
  rf_wb_scheduler #(.DW(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [4:0] a; logic [31:0] d; } res_t;
  res_t mbuf[$];
  logic [31:0] mbusy = '0;
  logic e_we = 1'b0;
  logic [4:0] e_addr = '0;
  logic [31:0] e_data = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.issue_valid = 0; bus.issue_rs_rd = 0; bus.issue_rt_rd = 0; bus.issue_we = 0; bus.issue_long = 0;
    bus.issue_rs = 0; bus.issue_rt = 0; bus.issue_dst = 0;
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
  endtask
  task automatic step();
    logic e_stall, e_ready;
    res_t r;
    #1;
    e_stall = !rst && bus.issue_valid && ((bus.issue_rs_rd && mbusy[bus.issue_rs]) ||
              (bus.issue_rt_rd && mbusy[bus.issue_rt]) || (bus.issue_we && mbusy[bus.issue_dst]));
    e_ready = !rst && mbuf.size() == 0;
    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("lu_ready", 64'(bus.lu_ready), 64'(e_ready));
    if (rst) begin
      mbusy = '0; mbuf.delete(); e_we = 0; e_addr = 0; e_data = 0;
    end else begin
      if (bus.wb_we && bus.wb_addr != 0) begin
        e_we = 1; e_addr = bus.wb_addr; e_data = bus.wb_data;
      end else if (mbuf.size() != 0) begin
        r = mbuf.pop_front();
        e_we = 1; e_addr = r.a; e_data = r.d; mbusy[r.a] = 1'b0;
      end else e_we = 0;
      if (bus.lu_valid && e_ready && bus.lu_addr != 0) mbuf.push_back('{bus.lu_addr, bus.lu_data});
      if (bus.issue_valid && !e_stall && bus.issue_long && bus.issue_we && bus.issue_dst != 0)
        mbusy[bus.issue_dst] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rf_we", 64'(bus.rf_we), 64'(e_we));
    chk("rf_waddr", 64'(bus.rf_waddr), 64'(e_addr));
    chk("rf_wdata", 64'(bus.rf_wdata), 64'(e_data));
    chk("busy_vec", 64'(bus.busy_vec), 64'(mbusy));
  endtask
  task automatic issue_long_op(input logic [4:0] dst);
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_we = 1; bus.issue_dst = dst;
    step();
    idle();
  endtask
  initial begin
    idle();
    @(negedge clk);
    rst = 1; bus.wb_we = 1; bus.wb_addr = 3; bus.wb_data = 32'h55; bus.lu_valid = 1; bus.lu_addr = 2;
    step(); step();
    rst = 0; idle();
    step();
    chk("ready_after_reset", 64'(bus.lu_ready), 64'd1);
    issue_long_op(5);
    bus.issue_valid = 1; bus.issue_rs_rd = 1; bus.issue_rs = 5;
    step();
    chk("raw_stall", 64'(bus.stall), 64'd1);
    bus.lu_valid = 1; bus.lu_addr = 5; bus.lu_data = 32'h1234;
    step();
    bus.lu_valid = 0;
    step(); step(); step();
    idle();
    issue_long_op(7);
    bus.lu_valid = 1; bus.lu_addr = 7; bus.lu_data = 32'h77;
    step();
    bus.lu_valid = 0; bus.wb_we = 1; bus.wb_addr = 3; bus.wb_data = 32'hAAAA;
    step(); step(); step();
    idle();
    step(); step();
    issue_long_op(9);
    bus.issue_valid = 1; bus.issue_we = 1; bus.issue_dst = 9;
    step(); step();
    bus.lu_valid = 1; bus.lu_addr = 9; bus.lu_data = 32'h99;
    step();
    bus.lu_valid = 0;
    step(); step(); step();
    idle();
    bus.wb_we = 1; bus.wb_addr = 0; bus.wb_data = 32'hDEAD;
    step();
    idle();
    issue_long_op(0);
    bus.lu_valid = 1; bus.lu_addr = 0; bus.lu_data = 32'hBEEF;
    step();
    idle();
    step();
    chk("r0_no_write", 64'(bus.rf_we), 64'd0);
    issue_long_op(4);
    bus.lu_valid = 1; bus.lu_addr = 4; bus.lu_data = 32'h44;
    step();
    bus.lu_valid = 0; bus.wb_we = 1; bus.wb_addr = 3; bus.wb_data = 32'h33;
    rst = 1;
    step();
    rst = 0; idle();
    step(); step(); step();
    chk("busy_cleared", 64'(bus.busy_vec), 64'd0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(127) == 0);
      bus.issue_valid = 1'($urandom_range(1));
      bus.issue_rs_rd = 1'($urandom_range(1));
      bus.issue_rt_rd = 1'($urandom_range(1));
      bus.issue_we = 1'($urandom_range(1));
      bus.issue_long = ($urandom_range(2) == 0);
      bus.issue_rs = 5'($urandom_range(7));
      bus.issue_rt = 5'($urandom_range(7));
      bus.issue_dst = 5'($urandom_range(7));
      bus.wb_we = ($urandom_range(2) == 0);
      bus.wb_addr = 5'($urandom_range(7));
      bus.wb_data = $urandom;
      bus.lu_valid = 1'($urandom_range(1));
      bus.lu_addr = 5'($urandom_range(7));
      bus.lu_data = $urandom;
      step();
    end
    rst = 0; idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
